// File: rtl/qlearn_pkg.sv
// Constants shared between the Q-learning accelerator and its policy driver:
// default widths, FSM state codes and the 16-bit Galois LFSR step.
package qlearn_pkg;

  localparam int QL_Q_W      = 16;
  localparam int QL_STATE_W  = 6;
  localparam int QL_ACTION_W = 4;

  // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_OFFER    = 3'd2;
  localparam logic [2:0] ST_WAIT_OBS = 3'd3;
  localparam logic [2:0] ST_UPDATE   = 3'd4;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/qlearn_argmax.sv
// Combinational signed argmax over a packed Q row; zero latency, no flow control.
// Ties resolve to the lowest action index.
module qlearn_argmax
  import qlearn_pkg::*;
#(
  parameter int NUM_ACTIONS = 4,
  parameter int Q_W         = QL_Q_W,
  parameter int IDX_W       = QL_ACTION_W
) (
  input  logic [NUM_ACTIONS*Q_W-1:0] row,
  output logic [IDX_W-1:0]           idx,
  output logic [Q_W-1:0]             max_val
);

  always_comb begin
    idx     = '0;
    max_val = row[Q_W-1:0];
    // strict greater-than keeps the earlier index on equal values
    for (int i = 1; i < NUM_ACTIONS; i++) begin
      if ($signed(row[i*Q_W +: Q_W]) > $signed(max_val)) begin
        idx     = IDX_W'(i);
        max_val = row[i*Q_W +: Q_W];
      end
    end
  end

endmodule

// File: rtl/qlearn_policy_driver.sv
// Epsilon-greedy episode sequencer feeding the Q-learning accelerator; step = 3 + HOLD_CYCLES cycles unstalled.
// Waits indefinitely on act_ready and obs_valid; accelerator inputs are held, never backpressured.
module qlearn_policy_driver
  import qlearn_pkg::*;
#(
  parameter int          NUM_ACTIONS = 4,
  parameter int          Q_W         = QL_Q_W,
  parameter int          STATE_W     = QL_STATE_W,
  parameter int          ACTION_W    = QL_ACTION_W,
  parameter int          HOLD_CYCLES = 4,
  parameter int          MAX_STEPS   = 256,
  parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [STATE_W-1:0]         init_state,
  input  logic [7:0]                 epsilon,
  output logic                       act_valid,
  output logic [ACTION_W-1:0]        act_action,
  input  logic                       act_ready,
  input  logic                       obs_valid,
  input  logic [STATE_W-1:0]         obs_state,
  input  logic [15:0]                obs_reward,
  input  logic                       obs_done,
  output logic                       acc_en,
  output logic [ACTION_W-1:0]        acc_action,
  output logic [STATE_W-1:0]         acc_state,
  output logic [STATE_W-1:0]         acc_next_state,
  output logic [15:0]                acc_reward,
  input  logic [NUM_ACTIONS*Q_W-1:0] q_row,
  output logic                       busy,
  output logic                       episode_done,
  output logic [15:0]                step_count
);

  localparam int          SEL_W      = $clog2(NUM_ACTIONS);
  localparam int          HOLD_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);

  logic [2:0]                 state;
  logic [15:0]                lfsr;
  logic [STATE_W-1:0]         cur_state;
  logic [ACTION_W-1:0]        action;
  logic                       first_step;
  logic [NUM_ACTIONS*Q_W-1:0] row;
  logic [STATE_W-1:0]         obs_state_q;
  logic [15:0]                obs_reward_q;
  logic                       obs_done_q;
  logic [HOLD_W-1:0]          hold_cnt;
  logic [15:0]                step_cnt;
  logic                       done_pulse;

  logic [ACTION_W-1:0] best_idx;
  logic [Q_W-1:0]      best_val_unused;
  logic                explore;
  logic [ACTION_W-1:0] rand_action;
  logic                hold_last;
  logic                in_update;

  qlearn_argmax #(
    .NUM_ACTIONS (NUM_ACTIONS),
    .Q_W         (Q_W),
    .IDX_W       (ACTION_W)
  ) u_argmax (
    .row     (row),
    .idx     (best_idx),
    .max_val (best_val_unused)
  );

  // First step of an episode has no valid row yet, so it always explores
  assign explore     = first_step || (lfsr[7:0] < epsilon);
  assign rand_action = ACTION_W'(lfsr[8 +: SEL_W]);
  assign hold_last   = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign in_update   = (state == ST_UPDATE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      lfsr         <= LFSR_SEED;
      cur_state    <= '0;
      action       <= '0;
      first_step   <= 1'b0;
      row          <= '0;
      obs_state_q  <= '0;
      obs_reward_q <= '0;
      obs_done_q   <= 1'b0;
      hold_cnt     <= '0;
      step_cnt     <= '0;
      done_pulse   <= 1'b0;
    end else begin
      lfsr       <= lfsr_step(lfsr);
      done_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_state  <= init_state;
            step_cnt   <= '0;
            first_step <= 1'b1;
            state      <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          action     <= explore ? rand_action : best_idx;
          first_step <= 1'b0;
          state      <= ST_OFFER;
        end
        ST_OFFER: begin
          if (act_ready) begin
            state <= ST_WAIT_OBS;
          end
        end
        ST_WAIT_OBS: begin
          if (obs_valid) begin
            obs_state_q  <= obs_state;
            obs_reward_q <= obs_reward;
            obs_done_q   <= obs_done;
            hold_cnt     <= '0;
            state        <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (hold_last) begin
            // accelerator output is valid on the final hold cycle
            row       <= q_row;
            step_cnt  <= step_cnt + 16'd1;
            cur_state <= obs_state_q;
            if (obs_done_q || (step_cnt + 16'd1 == STEP_LIMIT)) begin
              done_pulse <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              state <= ST_SELECT;
            end
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state != ST_IDLE);
  assign act_valid    = (state == ST_OFFER);
  assign act_action   = action;
  assign episode_done = done_pulse;
  assign step_count   = step_cnt;

  assign acc_en         = in_update;
  assign acc_action     = in_update ? action       : '0;
  assign acc_state      = in_update ? cur_state    : '0;
  assign acc_next_state = in_update ? obs_state_q  : '0;
  assign acc_reward     = in_update ? obs_reward_q : '0;

endmodule

// File: tb/tb_qlearn_policy_driver.sv
// Directed and randomized episodes against a transaction-level model of the policy driver.
module tb_qlearn_policy_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  init_state = '0;
  logic [7:0]  epsilon = '0;
  logic        act_ready = 1'b0;
  logic        obs_valid = 1'b0;
  logic [5:0]  obs_state = '0;
  logic [15:0] obs_reward = '0;
  logic        obs_done = 1'b0;
  logic [63:0] q_row = '0;

  logic        act_valid;
  logic [3:0]  act_action;
  logic        acc_en;
  logic [3:0]  acc_action;
  logic [5:0]  acc_state;
  logic [5:0]  acc_next_state;
  logic [15:0] acc_reward;
  logic        busy;
  logic        episode_done;
  logic [15:0] step_count;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [15:0] m_lfsr, m_lfsr_prev;
  logic [5:0]  m_cur;
  int          m_steps;
  logic        m_first;
  logic [63:0] m_row;
  logic [3:0]  last_action, last_exp, pu_exp;
  logic        dn;

  qlearn_policy_driver dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .init_state     (init_state),
    .epsilon        (epsilon),
    .act_valid      (act_valid),
    .act_action     (act_action),
    .act_ready      (act_ready),
    .obs_valid      (obs_valid),
    .obs_state      (obs_state),
    .obs_reward     (obs_reward),
    .obs_done       (obs_done),
    .acc_en         (acc_en),
    .acc_action     (acc_action),
    .acc_state      (acc_state),
    .acc_next_state (acc_next_state),
    .acc_reward     (acc_reward),
    .q_row          (q_row),
    .busy           (busy),
    .episode_done   (episode_done),
    .step_count     (step_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // LFSR free-runs from the seed on every edge out of reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr      <= 16'hACE1;
      m_lfsr_prev <= 16'hACE1;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= lfsr_next(m_lfsr);
    end
  end

  function automatic int best_action(input logic [63:0] r);
    int vals[4];
    int mx;
    for (int i = 0; i < 4; i++) vals[i] = int'($signed(r[i*16 +: 16]));
    mx = vals[0];
    foreach (vals[i]) if (vals[i] > mx) mx = vals[i];
    foreach (vals[i]) if (vals[i] == mx) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_act_valid"}, act_valid, 0);
    check({tag, "_act_action"}, act_action, 0);
    check({tag, "_acc_en"}, acc_en, 0);
    check({tag, "_acc_action"}, acc_action, 0);
    check({tag, "_acc_state"}, acc_state, 0);
    check({tag, "_acc_next_state"}, acc_next_state, 0);
    check({tag, "_acc_reward"}, acc_reward, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_episode_done"}, episode_done, 0);
    check({tag, "_step_count"}, step_count, 0);
  endtask

  task automatic start_episode(input logic [5:0] s, input logic [7:0] eps);
    epsilon    = eps;
    init_state = s;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    init_state = 6'($urandom);
    m_cur   = s;
    m_steps = 0;
    m_first = 1'b1;
    check("start_busy", busy, 1);
    check("start_step_count", step_count, 0);
    check("start_no_valid_in_select", act_valid, 0);
    @(negedge clk);
    check("start_to_act_valid", act_valid, 1);
  endtask

  task automatic do_step(input logic [5:0] ns, input logic [15:0] rew, input logic done,
                         input logic [63:0] qn, input int rdy_delay, input int obs_delay,
                         input bit rst_mid);
    int n;
    int hold;
    logic [3:0] exp_act;
    n = 0;
    while (act_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("act_valid_wait", act_valid, 1);
    if (m_first || (m_lfsr_prev[7:0] < epsilon)) exp_act = {2'b00, m_lfsr_prev[9:8]};
    else exp_act = 4'(best_action(m_row));
    check("act_action", act_action, exp_act);
    check("busy_offer", busy, 1);
    last_action = act_action;
    last_exp    = exp_act;
    m_first     = 1'b0;
    for (int i = 0; i < rdy_delay; i++) begin
      obs_valid = 1'($urandom);
      obs_state = 6'($urandom);
      @(negedge clk);
      check("stall_act_valid", act_valid, 1);
      check("stall_act_action", act_action, exp_act);
    end
    obs_valid = 1'b0;
    act_ready = 1'b1;
    @(negedge clk);
    act_ready = 1'b0;
    check("act_valid_drop", act_valid, 0);
    repeat (obs_delay) @(negedge clk);
    check("wait_obs_acc_en", acc_en, 0);
    obs_valid  = 1'b1;
    obs_state  = ns;
    obs_reward = rew;
    obs_done   = done;
    q_row      = {$urandom, $urandom};
    @(negedge clk);
    obs_valid  = 1'b0;
    obs_state  = 6'($urandom);
    obs_reward = 16'($urandom);
    obs_done   = 1'($urandom);
    hold = 0;
    while (acc_en === 1'b1 && hold < 10) begin
      check("acc_state", acc_state, m_cur);
      check("acc_action", acc_action, exp_act);
      check("acc_next_state", acc_next_state, ns);
      check("acc_reward", acc_reward, rew);
      check("update_no_done", episode_done, 0);
      q_row = (hold == 3) ? qn : {$urandom, $urandom};
      if (rst_mid && hold == 1) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        return;
      end
      hold++;
      @(negedge clk);
    end
    check("acc_en_cycles", hold, 4);
    m_steps++;
    m_cur = ns;
    m_row = qn;
    check("step_count", step_count, 16'(m_steps));
    if (done || m_steps == 256) begin
      check("episode_done_pulse", episode_done, 1);
      check("busy_after_end", busy, 0);
      @(negedge clk);
      check("episode_done_single", episode_done, 0);
    end else begin
      check("episode_continues", episode_done, 0);
      check("busy_continue", busy, 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // directed episode: tie-break, signed max, stall, terminal on step 3
    start_episode(6'd5, 8'd0);
    do_step(6'd9, -16'sd10, 1'b0, {16'sd5, -16'sd3, 16'sd9, 16'sd9}, 0, 0, 1'b0);
    pu_exp = last_exp;
    check("step1_count", step_count, 1);
    start      = 1'b1;
    init_state = 6'd33;
    @(negedge clk);
    start      = 1'b0;
    do_step(6'd12, 16'sd3, 1'b0, {-16'sd1, -16'sd2, -16'sd7, -16'sd4}, 0, 2, 1'b0);
    check("tie_break_low_index", last_action, 0);
    do_step(6'd20, 16'sd100, 1'b1, {$urandom, $urandom}, 10, 0, 1'b0);
    check("signed_max_action", last_action, 3);
    check("done_step_count", step_count, 3);
    check("done_busy", busy, 0);

    // randomized episodes
    for (int e = 0; e < 12; e++) begin
      start_episode(6'($urandom), 8'($urandom));
      for (int k = 0; k < 8; k++) begin
        dn = (k == 7) || ($urandom_range(0, 3) == 0);
        do_step(6'($urandom), 16'($urandom), dn, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        if (dn) break;
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // step limit ends the episode without obs_done
    start_episode(6'd1, 8'd255);
    for (int k = 0; k < 256; k++) begin
      do_step(6'($urandom), 16'($urandom), 1'b0, {$urandom, $urandom}, 0, 0, 1'b0);
    end
    check("limit_busy", busy, 0);
    check("limit_step_count", step_count, 256);

    // asynchronous reset in the middle of an update, then replay from power-up
    start_episode(6'd3, 8'd0);
    do_step(6'd4, 16'sd7, 1'b0, 64'd0, 0, 0, 1'b1);
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");
    rst   = 1'b0;
    m_row = '0;
    repeat (2) @(negedge clk);
    check("post_rst_no_pulse", episode_done, 0);
    start_episode(6'd5, 8'd0);
    do_step(6'd9, -16'sd10, 1'b1, {$urandom, $urandom}, 0, 0, 1'b0);
    check("reset_replay_action", last_action, pu_exp);
    check("replay_step_count", step_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
